// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: decode/execute controls, ROM address/data and the IF/ID stage outputs.
interface instr_fetch_unit_if;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] pc_out;
    logic [8:0]  instr_in;
    logic [8:0]  instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        input  start,
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  instr_in,
        output pc_out,
        output instr_out,
        output instr_pc,
        output instr_valid,
        output halted,
        output fetch_count
    );

    modport slave (
        output start,
        output stall,
        output branch_taken,
        output branch_target,
        output instr_in,
        input  pc_out,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, IF/ID register, branch redirect/squash,
// HALT detection and a saturating delivered-instruction counter.
module instr_fetch_unit #(
    parameter logic [15:0] START_PC    = 16'h0000,
    parameter logic [8:0]  HALT_OPCODE = 9'b111111111
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_fetch_unit_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_pc;
    logic [8:0]  r_instr;
    logic [15:0] r_instr_pc;
    logic        r_valid;
    logic        r_halted;
    logic [15:0] r_count;

    logic [15:0] w_pc_nxt;
    logic [8:0]  w_instr_nxt;
    logic [15:0] w_instr_pc_nxt;
    logic        w_valid_nxt;
    logic        w_halted_nxt;
    logic [15:0] w_count_nxt;
    logic [15:0] w_count_inc;
    logic        w_is_halt;

    assign w_count_inc = (r_count == '1) ? r_count : r_count + 16'd1;
    assign w_is_halt   = (bus.instr_in == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= START_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_halted   <= w_halted_nxt;
            r_count    <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_halted_nxt   = r_halted;
        w_count_nxt    = r_count;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = START_PC;
                end
            end
            ST_RUN: begin
                // Redirect squashes the word at the current pc; it outranks stall and HALT.
                if (bus.branch_taken) begin
                    w_pc_nxt    = bus.branch_target;
                    w_valid_nxt = 1'b0;
                end else if (!bus.stall) begin
                    w_instr_nxt    = bus.instr_in;
                    w_instr_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_count_nxt    = w_count_inc;
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt = r_pc + 16'd1;
                    end
                end
            end
            ST_HALT: begin
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b1;
                if (bus.start) begin
                    w_state_nxt  = ST_RUN;
                    w_pc_nxt     = START_PC;
                    w_halted_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.pc_out      = r_pc;
    assign bus.instr_out   = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle reference model plus a delivered-instruction scoreboard.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    logic halt_en;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .START_PC    (16'h0000),
        .HALT_OPCODE (9'h1FF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] rom_word(input logic [15:0] addr, input logic hen);
        logic [8:0] v;
        if (hen && addr == 16'd9) begin
            v = 9'h1FF;
        end else begin
            v = addr[8:0] * 9'd5 + 9'd3;
            if (v == 9'h1FF) v = 9'h000;
        end
        return v;
    endfunction

    always_comb bus.instr_in = rom_word(bus.pc_out, halt_en);

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_HALT} mstate_t;
    typedef struct packed {
        logic [8:0]  ins;
        logic [15:0] pc;
    } fetch_t;

    mstate_t     m_state;
    logic [15:0] m_pc;
    logic [8:0]  m_ins;
    logic [15:0] m_ipc;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_count;
    logic        m_deliv;
    fetch_t      sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [8:0] w;
        m_deliv = 1'b0;
        if (reset) begin
            m_state  = M_IDLE;
            m_pc     = 16'h0000;
            m_ins    = 9'h000;
            m_ipc    = 16'h0000;
            m_valid  = 1'b0;
            m_halted = 1'b0;
            m_count  = 16'h0000;
            sb_q.delete();
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (bus.start) begin
                        m_state = M_RUN;
                        m_pc    = 16'h0000;
                    end
                end
                M_RUN: begin
                    if (bus.branch_taken) begin
                        m_pc    = bus.branch_target;
                        m_valid = 1'b0;
                    end else if (!bus.stall) begin
                        w       = rom_word(m_pc, halt_en);
                        m_ins   = w;
                        m_ipc   = m_pc;
                        m_valid = 1'b1;
                        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                        sb_q.push_back('{ins: w, pc: m_pc});
                        m_deliv = 1'b1;
                        if (w == 9'h1FF) m_state = M_HALT;
                        else             m_pc    = m_pc + 16'd1;
                    end
                end
                default: begin
                    m_valid  = 1'b0;
                    m_halted = 1'b1;
                    if (bus.start) begin
                        m_state  = M_RUN;
                        m_pc     = 16'h0000;
                        m_halted = 1'b0;
                    end
                end
            endcase
        end
    endtask

    task automatic compare(input bit full);
        fetch_t e;
        if (m_deliv) begin
            if (sb_q.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_instr", 32'(bus.instr_out), 32'(e.ins));
                check("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
                check("sb_valid", 32'(bus.instr_valid), 32'd1);
            end
        end
        if (full) begin
            check("pc_out", 32'(bus.pc_out), 32'(m_pc));
            check("instr_out", 32'(bus.instr_out), 32'(m_ins));
            check("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
            check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
            check("halted", 32'(bus.halted), 32'(m_halted));
            check("fetch_count", 32'(bus.fetch_count), 32'(m_count));
        end
    endtask

    task automatic tick(input bit full = 1'b1);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare(full);
    endtask

    logic [15:0] saved_count;

    initial begin
        reset             = 1'b1;
        halt_en           = 1'b1;
        bus.start         = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 16'h0000;
        m_state = M_IDLE; m_pc = '0; m_ins = '0; m_ipc = '0;
        m_valid = 1'b0; m_halted = 1'b0; m_count = '0; m_deliv = 1'b0;

        tick(); tick();
        reset = 1'b0;
        check("rst_pc", 32'(bus.pc_out), 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_count", 32'(bus.fetch_count), 32'h0);
        check("rst_instr", 32'(bus.instr_out), 32'h0);

        // IDLE ignores stall and branch
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h1234;
        repeat (3) tick();
        check("idle_pc", 32'(bus.pc_out), 32'h0);
        bus.stall = 1'b0; bus.branch_taken = 1'b0;

        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("start_pc", 32'(bus.pc_out), 32'h0);
        check("start_valid", 32'(bus.instr_valid), 32'h0);
        repeat (5) tick();
        check("run_pc5", 32'(bus.pc_out), 32'h5);
        check("run_ipc4", 32'(bus.instr_pc), 32'h4);
        check("run_count5", 32'(bus.fetch_count), 32'h5);

        bus.stall = 1'b1;
        repeat (3) tick();
        check("stall_pc", 32'(bus.pc_out), 32'h5);
        check("stall_ipc", 32'(bus.instr_pc), 32'h4);
        check("stall_valid", 32'(bus.instr_valid), 32'h1);
        check("stall_count", 32'(bus.fetch_count), 32'h5);
        bus.stall = 1'b0;
        tick();
        check("unstall_ipc", 32'(bus.instr_pc), 32'h5);
        tick();
        check("pre_br_pc", 32'(bus.pc_out), 32'h7);

        bus.branch_taken = 1'b1; bus.branch_target = 16'h0020;
        tick(); bus.branch_taken = 1'b0;
        check("br_pc", 32'(bus.pc_out), 32'h20);
        check("br_bubble", 32'(bus.instr_valid), 32'h0);
        tick();
        check("br_ipc", 32'(bus.instr_pc), 32'h20);
        check("br_valid", 32'(bus.instr_valid), 32'h1);

        bus.branch_taken = 1'b1; bus.stall = 1'b1; bus.branch_target = 16'h0040;
        tick(); bus.branch_taken = 1'b0; bus.stall = 1'b0;
        check("brst_pc", 32'(bus.pc_out), 32'h40);
        check("brst_bubble", 32'(bus.instr_valid), 32'h0);
        tick();
        check("brst_ipc", 32'(bus.instr_pc), 32'h40);

        // branch on the HALT word squashes it and stays in RUN
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0009;
        tick();
        bus.branch_target = 16'h0030;
        tick(); bus.branch_taken = 1'b0;
        check("brhalt_halted", 32'(bus.halted), 32'h0);
        check("brhalt_pc", 32'(bus.pc_out), 32'h30);
        tick();
        check("brhalt_ipc", 32'(bus.instr_pc), 32'h30);

        bus.branch_taken = 1'b1; bus.branch_target = 16'h0008;
        tick(); bus.branch_taken = 1'b0;
        tick(); tick();
        check("halt_instr", 32'(bus.instr_out), 32'h1FF);
        check("halt_ipc", 32'(bus.instr_pc), 32'h9);
        check("halt_dvalid", 32'(bus.instr_valid), 32'h1);
        for (int i = 0; i < 12; i++) begin
            bus.branch_taken  = 1'b1;
            bus.branch_target = 16'h0055;
            bus.stall         = 1'(i % 2);
            tick();
        end
        bus.branch_taken = 1'b0; bus.stall = 1'b0;
        check("halt_flag", 32'(bus.halted), 32'h1);
        check("halt_valid", 32'(bus.instr_valid), 32'h0);
        check("halt_pc", 32'(bus.pc_out), 32'h9);
        saved_count = bus.fetch_count;

        halt_en = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("restart_pc", 32'(bus.pc_out), 32'h0);
        check("restart_halted", 32'(bus.halted), 32'h0);
        check("restart_count", 32'(bus.fetch_count), 32'(saved_count));

        bus.start = 1'b1; repeat (3) tick(); bus.start = 1'b0;
        check("run_start_ign", 32'(bus.pc_out), 32'h3);

        bus.branch_taken = 1'b1; bus.branch_target = 16'hFFFF;
        tick(); bus.branch_taken = 1'b0;
        tick();
        check("wrap_pc", 32'(bus.pc_out), 32'h0);
        check("wrap_ipc", 32'(bus.instr_pc), 32'hFFFF);

        for (int i = 0; i < 70000 && m_count != 16'hFFFF; i++) tick(i % 4096 == 0);
        repeat (4) tick();
        check("sat_count", 32'(bus.fetch_count), 32'hFFFF);

        reset = 1'b1; bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h0077;
        tick();
        reset = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0;
        check("mrst_pc", 32'(bus.pc_out), 32'h0);
        check("mrst_valid", 32'(bus.instr_valid), 32'h0);
        check("mrst_count", 32'(bus.fetch_count), 32'h0);
        check("mrst_ipc", 32'(bus.instr_pc), 32'h0);
        repeat (3) tick();
        check("mrst_idle_pc", 32'(bus.pc_out), 32'h0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick(); tick();
        check("resume_ipc", 32'(bus.instr_pc), 32'h1);
        check("resume_count", 32'(bus.fetch_count), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
